// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-serial data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Big-endian byte select: idx 0 is bits 31:24, idx 3 is bits 7:0.
  function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [31:0] sh;
    sh = word << (8 * idx);
    return sh[31:24];
  endfunction

endpackage

// File: rtl/dmem_be_pack.sv
// Big-endian 4x8 assembly register; word shows the contents with any pending load merged in.
module dmem_be_pack
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld,
  input  logic [1:0]  idx,
  input  logic [7:0]  din,
  output logic [31:0] word
);

  logic [31:0] word_q;

  always_comb begin
    word = word_q;
    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      if (ld && idx == 2'(i)) word[31 - 8*i -: 8] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) word_q <= '0;
    else        word_q <= word;
  end

endmodule

// File: rtl/dmem_byte_ctrl.sv
// Sequences one 32-bit request into four big-endian byte accesses on a byte-wide synchronous memory.
module dmem_byte_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_t            state;
  logic [1:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic              pack_ld;
  logic [1:0]        pack_idx;
  logic [31:0]       pack_word;
  logic              xfer;
  logic              misaligned;

  // Read data lags the address by one cycle, so XFER cnt>0 captures byte cnt-1 and CAPTURE takes byte 3.
  assign pack_ld  = (state == XFER && cnt != 2'd0 && !we_q) || state == CAPTURE;
  assign pack_idx = (state == CAPTURE) ? 2'd3 : cnt - 2'd1;

  dmem_be_pack u_pack (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (pack_ld),
    .idx   (pack_idx),
    .din   (mem_rdata),
    .word  (pack_word)
  );

  assign misaligned = |req_addr[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          err_q   <= misaligned;
          cnt     <= '0;
          state   <= misaligned ? RESP : XFER;
        end
        XFER: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= we_q ? RESP : CAPTURE;
        end
        CAPTURE: begin
          rdata_q <= pack_word;
          state   <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are masked while rst_n is low so an in-flight byte is not written on the reset edge.
  assign xfer      = (state == XFER) && rst_n;
  assign mem_en    = xfer;
  assign mem_we    = xfer && we_q;
  assign mem_addr  = xfer ? addr_q + ADDR_W'(cnt) : '0;
  assign mem_wdata = xfer ? be_byte(wdata_q, cnt) : '0;

  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = (state == RESP) && rst_n;
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: doc/dmem_byte_ctrl.md
Name: dmem_byte_ctrl

Overview:
Multi-cycle data-memory access controller between the processor's load/store path and a byte-wide synchronous data memory. It accepts one 32-bit word request at a time and sequences four byte transfers in big-endian order (lowest address holds bits 31:24). It then returns a single-cycle response. It replaces the processor's combinational four-byte memory access and gives the core a ready/valid stall point.

Parameters:
ADDR_W, 5, byte-address width of data memory; addresses wrap modulo 2^ADDR_W.

Ports:
clk  in  1  system clock; all state changes on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
req_valid  in  1  processor presents a load/store request
req_ready  out  1  controller can accept a request; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address of the word
req_wdata  in  32  store data
rsp_valid  out  1  one-cycle pulse when the request completes
rsp_rdata  out  32  load data; holds its value until the next load response
rsp_err  out  1  qualifies rsp_valid; 1 = misaligned request, no memory access made
busy  out  1  equals ~req_ready; drives the processor stall
mem_en  out  1  byte memory enable
mem_we  out  1  byte memory write enable
mem_addr  out  ADDR_W  byte memory address
mem_wdata  out  8  byte write data
mem_rdata  in  8  byte read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- States: IDLE, XFER, CAPTURE, RESP. Byte counter cnt is 2 bits.
- Reset values: state=IDLE, cnt=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, latched request=0.
- IDLE: req_ready=1. On an edge with req_valid=1:
  - latch req_we, req_addr and req_wdata;
  - if req_addr[1:0]!=0, go to RESP with err flag set;
  - otherwise go to XFER with cnt=0.
- XFER: mem_en=1, mem_we=latched we, mem_addr=(base+cnt) mod 2^ADDR_W, mem_wdata=wdata byte (3-cnt). This is big-endian: cnt 0 → bits 31:24, cnt 3 → bits 7:0.
  - Load: when cnt>0, capture mem_rdata into shift-assembly byte (cnt-1).
  - At the edge, cnt increments. When cnt==3: a load goes to CAPTURE, a store goes to RESP.
- CAPTURE (loads only): mem_en=0; capture mem_rdata as bits 7:0; go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_err=err flag.
  - A successful load updates rsp_rdata from the assembly register at entry to RESP. Stores and errors leave rsp_rdata unchanged.
  - Next state is IDLE.
- Latency, with accept at edge E0:
  - load: XFER cycles 1–4, CAPTURE cycle 5, rsp_valid in cycle 6;
  - store: rsp_valid in cycle 5;
  - misaligned: rsp_valid in cycle 1.
- mem_en is 0 in IDLE, CAPTURE and RESP.
- req_valid outside IDLE is ignored. A request held through RESP is accepted in the following IDLE cycle (back-to-back spacing of 7 cycles for loads).
- Address wrap: base=0x1C gives bytes 0x1C–0x1F. No carry beyond ADDR_W bits; aligned requests never wrap.
- Request fields change after acceptance: no effect; the latched copy is used.
- Reset mid-operation: next cycle is IDLE with mem_en=0 and no rsp_valid. Bytes already written stay written (no rollback).
- No response backpressure: the processor must sample rsp_valid in its pulse cycle.

Decomposition:
- Package dmem_pkg holds:
  - state enum {IDLE, XFER, CAPTURE, RESP};
  - BYTES_PER_WORD=4;
  - function be_byte(word, idx) returning bits [31-8*idx -: 8].
- Sub-module dmem_be_pack: 4×8 big-endian assembly register with load-enable and byte index.
- The FSM stays in dmem_byte_ctrl.

Test Plan:
- Store addr=0x08, wdata=0xDEADBEEF → writes 0xDE@0x08, 0xAD@0x09, 0xBE@0x0A, 0xEF@0x0B in consecutive cycles; rsp_valid in cycle 5, rsp_err=0, rsp_rdata unchanged.
- Memory preloaded 0x12,0x34,0x56,0x78 at 0x1C–0x1F; load addr=0x1C → mem_addr 0x1C..0x1F, rsp_valid in cycle 6, rsp_rdata=0x12345678, rsp_err=0.
- Load addr=0x06 → rsp_valid in cycle 1, rsp_err=1, mem_en never asserted, rsp_rdata keeps its prior value.
- req_valid held high with two queued stores (0x00←0x11223344, then 0x04←0x55667788) → second accepted only when req_ready returns; readback loads give both words exactly.
- Store addr=0x10 wdata=0xAABBCCDD with rst_n low in the cycle after byte 1 (0xBB@0x11) → 0x10=0xAA, 0x11=0xBB, 0x12/0x13 untouched; all outputs at reset values; no rsp_valid; a new request is accepted next cycle.
- Request fields changed during XFER → result matches the original latched request.
